stream_mux_rr: RTL

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

---
 rtl/stream_mux_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/stream_mux_rr.sv | 124 ++++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared constants and encodings for the round-robin stream mux
// Contents:
//   DEFAULT_DATA_WIDTH / DEFAULT_NUM_CH : default parameter values for stream_mux_rr
//   mode_e                              : MODE_RR = 0 (round-robin), MODE_FIXED = 1 (select via s)
//   lock_state_e                        : packet-lock state, used when STREAM_MUX_LOCK_EN is defined
package stream_mux_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_NUM_CH     = 4;

    typedef enum logic {
        MODE_RR    = 1'b0,
        MODE_FIXED = 1'b1
    } mode_e;

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant over a request vector with a last-grant pointer
// Ports:
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   req           : NUM_CH request bits
//   advance       : high when the current grant was accepted; moves the pointer
//   grant_onehot  : combinational one-hot grant (zero when no request)
//   grant_idx     : index of the granted channel (zero when no request)
module rr_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int SEL_WIDTH = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    req,
    input  logic                 advance,
    output logic [NUM_CH-1:0]    grant_onehot,
    output logic [SEL_WIDTH-1:0] grant_idx
);

    logic [SEL_WIDTH-1:0] last_grant;
    logic                 found;
    int                   idx;

    // Search upward from the channel after the last winner, wrapping around.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        idx          = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(last_grant) + 1 + i) % NUM_CH;
            if (!found && req[idx]) begin
                found             = 1'b1;
                grant_onehot[idx] = 1'b1;
                grant_idx         = SEL_WIDTH'(idx);
            end
        end
    end

    // Reset to NUM_CH-1 so that channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= SEL_WIDTH'(NUM_CH - 1);
        end else if (advance) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-to-1 valid/ready stream mux, round-robin or fixed select, registered output
// Ports:
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   mode                 : 0 = round-robin, 1 = fixed select via s
//   s                    : fixed-select channel index (no grant when s >= NUM_CH)
//   in_valid / in_ready  : per-channel handshake; in_ready is one-hot or zero
//   in_data              : channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid / out_ready: output register handshake
//   out_data, out_sel    : registered beat and its source channel
//   in_last, out_last    : packet delimiters, present only with STREAM_MUX_LOCK_EN defined;
//                          a started packet keeps the grant until its last beat is accepted
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_CH     = DEFAULT_NUM_CH,
    parameter int SEL_WIDTH  = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode,
    input  logic [SEL_WIDTH-1:0]         s,
    input  logic [NUM_CH-1:0]            in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
`ifdef STREAM_MUX_LOCK_EN
    input  logic [NUM_CH-1:0]            in_last,
    output logic                         out_last,
`endif
    output logic [NUM_CH-1:0]            in_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [SEL_WIDTH-1:0]         out_sel,
    input  logic                         out_ready
);

    logic [NUM_CH-1:0]    sel_mask;
    logic [NUM_CH-1:0]    policy_req;
    logic [NUM_CH-1:0]    req;
    logic [NUM_CH-1:0]    grant_onehot;
    logic [SEL_WIDTH-1:0] grant_idx;
    logic                 can_load;
    logic                 accept;

    // Requests allowed by the current mode; an out-of-range s masks everything.
    always_comb begin
        sel_mask = '0;
        if (int'(s) < NUM_CH) begin
            sel_mask[s] = 1'b1;
        end
        policy_req = (mode == MODE_FIXED) ? (in_valid & sel_mask) : in_valid;
    end

`ifdef STREAM_MUX_LOCK_EN
    lock_state_e          lock_state;
    lock_state_e          lock_next;
    logic [SEL_WIDTH-1:0] lock_ch;
    logic [SEL_WIDTH-1:0] lock_ch_next;
    logic [NUM_CH-1:0]    lock_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_state <= LOCK_IDLE;
            lock_ch    <= '0;
        end else begin
            lock_state <= lock_next;
            lock_ch    <= lock_ch_next;
        end
    end

    // Any accepted non-last beat opens a lock on its channel; a last beat releases it.
    always_comb begin
        lock_next    = lock_state;
        lock_ch_next = lock_ch;
        lock_mask    = '0;
        lock_mask[lock_ch] = 1'b1;
        if (accept) begin
            lock_ch_next = grant_idx;
            lock_next    = in_last[grant_idx] ? LOCK_IDLE : LOCK_HELD;
        end
    end

    // While locked, mode and s are ignored: only the locked channel may request.
    assign req = (lock_state == LOCK_HELD) ? (in_valid & lock_mask) : policy_req;
`else
    assign req = policy_req;
`endif

    rr_arbiter #(
        .NUM_CH    (NUM_CH),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_arb (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .advance      (accept),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    assign can_load = !out_valid || out_ready;
    assign in_ready = (can_load && !rst) ? grant_onehot : '0;
    assign accept   = |in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
`ifdef STREAM_MUX_LOCK_EN
            out_last  <= 1'b0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            out_sel   <= grant_idx;
`ifdef STREAM_MUX_LOCK_EN
            out_last  <= in_last[grant_idx];
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
